ps2_letter_fifo: RTL and testbench
==================================

Name: ps2_letter_fifo

Overview:
- PS/2 set-2 keyboard receiver, the successor to the current kbdWrapper path.
- Synchronises kbdclk/kbddat, deframes 11-bit frames, tracks F0/E0 prefixes and decodes make codes to 5-bit letter codes.
- Buffers letters in a parametrised FIFO with a valid/ready output so downstream display or game logic never misses keystrokes.
- Also holds the most recent letter for direct 7-segment/LED display.

Parameters:
- FIFO_DEPTH, 8, letter FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flip-flops in each kbdclk/kbddat synchroniser; minimum 2.
- TIMEOUT_CYC, 200000, clk cycles without a kbdclk falling edge before a partial frame is abandoned (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- kbdclk  in  1  raw PS/2 clock.
- kbddat  in  1  raw PS/2 data.
- letter_out  out  5  FIFO head letter code.
- letter_valid  out  1  FIFO non-empty.
- letter_ready  in  1  consumer accepts head when letter_valid is high.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- last_letter  out  5  most recent decoded letter, held until the next one arrives.
- overflow  out  1  sticky; a letter was dropped because the FIFO was full.
- frame_err  out  1  sticky; start, stop or parity error seen.
- err_clr  in  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset values: letter_out=0, letter_valid=0, fifo_count=0, last_letter=5'h1F (blank), overflow=0, frame_err=0. Frame FSM goes to IDLE; prefix flags clear; FIFO pointers clear.
- Reset is asynchronous. A reset mid-frame discards the partial frame.
- Synchronisation and edge detect: kbdclk and kbddat each pass through SYNC_STAGES flops. A falling edge of the synchronised kbdclk produces a one-cycle fall pulse; data is sampled on that cycle.
- Frame FSM:
  - IDLE -> SHIFT on a fall pulse with data=0 (start bit). A fall pulse with data=1 in IDLE is ignored.
  - SHIFT collects 8 data bits LSB-first, then parity, then stop.
  - SHIFT -> CHECK on the 11th fall pulse.
  - CHECK (1 cycle): frame is valid iff stop=1 and the parity bit makes the 9 bits odd. Invalid frame sets frame_err and is discarded. CHECK -> IDLE.
  - Watchdog counter resets on each fall pulse. When it reaches TIMEOUT_CYC while in SHIFT, the FSM returns to IDLE silently; frame_err is not set.
- Prefix handling (cycle after CHECK):
  - Byte E0 sets ext; byte F0 sets brk; no output.
  - Any other byte clears both flags. It is decoded only if ext=0 and brk=0; break and extended codes are dropped.
  - Typematic repeats are decoded as ordinary make codes.
- Decode table (scancode->letter):
  - A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A give codes 0..25.
  - Space(29)=26, Enter(5A)=27, Backspace(66)=28.
  - Any other byte is dropped with no error.
- Latency: the fall pulse of the stop bit is cycle E. CHECK is E+1, decode/push is E+2, letter_valid rises at E+3 when the FIFO was empty. last_letter updates at E+3.
- FIFO:
  - Pop occurs when letter_valid && letter_ready.
  - Push when full and no pop: letter is dropped, overflow set.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when empty cannot occur, since valid is low.
  - letter_out is registered and holds its value when letter_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- err_clr and a simultaneous new error in the same cycle: the error wins and the flag stays set.

Optional Feature:
- PS2_BREAK_EVENTS_EN.
- When defined:
  - letter_out and last_letter widen to 6 bits, with bit 5 = release.
  - F0-prefixed mapped codes are pushed with bit 5 set.
  - last_letter updates on make events only.
- When undefined: 5-bit outputs and break codes are dropped as described above.

Test Plan:
- Send frame 0x1C (correct odd parity), letter_ready=0 -> letter_valid rises E+3, letter_out=0, fifo_count=1, last_letter=0.
- Send F0 1C then 1A -> exactly one push, letter_out=25 (Z); the break is dropped. With PS2_BREAK_EVENTS_EN defined: pushes 6'h20, then 6'h19.
- Send 0x24 with the parity bit flipped -> frame_err=1, fifo_count unchanged. Pulse err_clr -> frame_err=0.
- FIFO_DEPTH=4, ready=0, send 5 mapped keys -> fifo_count=4, overflow=1. Then send a key while popping with ready=1 -> count stays 4, overflow unchanged.
- Send 6 bits of a frame, idle for TIMEOUT_CYC+10 cycles, then a full 0x29 frame -> letter_out=26, frame_err=0.
- Assert rst mid-frame, release, send 0x5A -> outputs at reset values, then letter_out=27.

Source files
------------

// File: rtl/ps2_letter_fifo.sv
// PS/2 set-2 keyboard receiver: deframes scancodes, decodes letters and queues them behind valid/ready.
// Build macro PS2_BREAK_EVENTS_EN widens letters to 6 bits and also queues key releases (bit 5 set).
module ps2_letter_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 200000,
`ifdef PS2_BREAK_EVENTS_EN
    localparam int LW = 6
`else
    localparam int LW = 5
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        kbdclk,
    input  logic                        kbddat,
    output logic [LW-1:0]               letter_out,
    output logic                        letter_valid,
    input  logic                        letter_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [LW-1:0]               last_letter,
    output logic                        overflow,
    output logic                        frame_err,
    input  logic                        err_clr
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic logic odd_parity9(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Returns {hit, letter}; hit=0 for bytes that have no letter.
    function automatic logic [5:0] decode_scancode(input logic [7:0] sc);
        logic [5:0] r;
        case (sc)
            8'h1C: r = {1'b1, 5'd0};
            8'h32: r = {1'b1, 5'd1};
            8'h21: r = {1'b1, 5'd2};
            8'h23: r = {1'b1, 5'd3};
            8'h24: r = {1'b1, 5'd4};
            8'h2B: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};
            8'h33: r = {1'b1, 5'd7};
            8'h43: r = {1'b1, 5'd8};
            8'h3B: r = {1'b1, 5'd9};
            8'h42: r = {1'b1, 5'd10};
            8'h4B: r = {1'b1, 5'd11};
            8'h3A: r = {1'b1, 5'd12};
            8'h31: r = {1'b1, 5'd13};
            8'h44: r = {1'b1, 5'd14};
            8'h4D: r = {1'b1, 5'd15};
            8'h15: r = {1'b1, 5'd16};
            8'h2D: r = {1'b1, 5'd17};
            8'h1B: r = {1'b1, 5'd18};
            8'h2C: r = {1'b1, 5'd19};
            8'h3C: r = {1'b1, 5'd20};
            8'h2A: r = {1'b1, 5'd21};
            8'h1D: r = {1'b1, 5'd22};
            8'h22: r = {1'b1, 5'd23};
            8'h35: r = {1'b1, 5'd24};
            8'h1A: r = {1'b1, 5'd25};
            8'h29: r = {1'b1, 5'd26};
            8'h5A: r = {1'b1, 5'd27};
            8'h66: r = {1'b1, 5'd28};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] kclk_sync_r;
    logic [SYNC_STAGES-1:0] kdat_sync_r;
    logic                   kclk_prev_r;
    logic                   fall_s;
    logic                   dat_s;

    state_t                 state_r;
    logic [3:0]             bit_cnt_r;
    logic [9:0]             shift_r;
    logic [WDW-1:0]         wd_r;
    logic                   frame_good_s;
    logic                   check_bad_s;

    logic                   byte_rdy_r;
    logic [7:0]             byte_r;
    logic                   ext_r;
    logic                   brk_r;
    logic [5:0]             dec_s;
    logic                   push_s;
    logic                   make_s;
    logic [LW-1:0]          push_data_s;

    logic [LW-1:0]          mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [AW-1:0]          rd_next_s;
    logic [AW:0]            count_r;
    logic [AW:0]            count_next_s;
    logic                   valid_r;
    logic [LW-1:0]          head_r;
    logic                   pop_s;
    logic                   full_s;
    logic                   wr_en_s;
    logic                   ovf_set_s;

    logic [LW-1:0]          last_r;
    logic                   ovf_r;
    logic                   ferr_r;

    // Synchronise the raw PS/2 lines and keep the previous clock level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_sync_r <= {SYNC_STAGES{1'b1}};
            kdat_sync_r <= {SYNC_STAGES{1'b1}};
            kclk_prev_r <= 1'b1;
        end else begin
            kclk_sync_r <= {kclk_sync_r[SYNC_STAGES-2:0], kbdclk};
            kdat_sync_r <= {kdat_sync_r[SYNC_STAGES-2:0], kbddat};
            kclk_prev_r <= kclk_sync_r[SYNC_STAGES-1];
        end
    end

    assign fall_s       = kclk_prev_r & ~kclk_sync_r[SYNC_STAGES-1];
    assign dat_s        = kdat_sync_r[SYNC_STAGES-1];
    assign frame_good_s = shift_r[9] & odd_parity9(shift_r[8:0]);
    assign check_bad_s  = (state_r == ST_CHECK) & ~frame_good_s;

    // Watchdog: cycles since the last kbdclk fall, saturating at the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_r <= {WDW{1'b0}};
        end else if (fall_s) begin
            wd_r <= {WDW{1'b0}};
        end else if (wd_r != WDW'(TIMEOUT_CYC)) begin
            wd_r <= wd_r + WDW'(1);
        end
    end

    // Frame FSM: start bit, 8 data bits LSB-first, parity and stop, then a one-cycle check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 10'd0;
            byte_rdy_r <= 1'b0;
            byte_r     <= 8'd0;
        end else begin
            byte_rdy_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s && !dat_s) begin
                        state_r   <= ST_SHIFT;
                        bit_cnt_r <= 4'd0;
                    end
                end
                ST_SHIFT: begin
                    if (fall_s) begin
                        shift_r   <= {dat_s, shift_r[9:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd9) begin
                            state_r <= ST_CHECK;
                        end
                    end else if (wd_r == WDW'(TIMEOUT_CYC)) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    byte_rdy_r <= frame_good_s;
                    byte_r     <= shift_r[7:0];
                    state_r    <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Prefix flags: E0/F0 arm ext/brk for the next byte; any other byte consumes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
        end else if (byte_rdy_r) begin
            if (byte_r == SC_EXT) begin
                ext_r <= 1'b1;
            end else if (byte_r == SC_BRK) begin
                brk_r <= 1'b1;
            end else begin
                ext_r <= 1'b0;
                brk_r <= 1'b0;
            end
        end
    end

    // Decode the received byte into a push request; E0/F0 never hit the table.
    always_comb begin
        dec_s       = decode_scancode(byte_r);
        push_s      = 1'b0;
        make_s      = 1'b0;
        push_data_s = {LW{1'b0}};
        if (byte_rdy_r && dec_s[5] && !ext_r) begin
`ifdef PS2_BREAK_EVENTS_EN
            push_s      = 1'b1;
            make_s      = ~brk_r;
            push_data_s = {brk_r, dec_s[4:0]};
`else
            if (!brk_r) begin
                push_s      = 1'b1;
                make_s      = 1'b1;
                push_data_s = dec_s[4:0];
            end else begin
                push_s      = 1'b0;
                make_s      = 1'b0;
            end
`endif
        end else begin
            push_s = 1'b0;
        end
    end

    assign pop_s        = valid_r & letter_ready;
    assign full_s       = (count_r == (AW+1)'(FIFO_DEPTH));
    assign wr_en_s      = push_s & (~full_s | pop_s);
    assign ovf_set_s    = push_s & full_s & ~pop_s;
    assign rd_next_s    = rd_ptr_r + AW'(1);
    assign count_next_s = count_r + {{AW{1'b0}}, wr_en_s} - {{AW{1'b0}}, pop_s};

    // Letter storage; the head copy lives in head_r so the output stays registered.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy, valid flag and registered head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            valid_r  <= 1'b0;
            head_r   <= {LW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {(AW+1){1'b0}});
            if (count_r == {(AW+1){1'b0}}) begin
                if (wr_en_s) begin
                    head_r <= push_data_s;
                end
            end else if (pop_s) begin
                if (count_r == (AW+1)'(1)) begin
                    if (wr_en_s) begin
                        head_r <= push_data_s;
                    end
                end else begin
                    head_r <= mem_r[rd_next_s];
                end
            end
        end
    end

    // Display letter and sticky error flags; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= LW'(5'h1F);
            ovf_r  <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            if (make_s) begin
                last_r <= push_data_s;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (err_clr) begin
                ovf_r <= 1'b0;
            end
            if (check_bad_s) begin
                ferr_r <= 1'b1;
            end else if (err_clr) begin
                ferr_r <= 1'b0;
            end
        end
    end

    assign letter_out   = head_r;
    assign letter_valid = valid_r;
    assign fifo_count   = count_r;
    assign last_letter  = last_r;
    assign overflow     = ovf_r;
    assign frame_err    = ferr_r;

endmodule

// File: tb/tb_ps2_letter_fifo.sv
// Self-checking bench for ps2_letter_fifo: directed scenarios plus random keystrokes against a queue model.
`timescale 1ns/1ps
module tb_ps2_letter_fifo;
    localparam int DEPTH = 4;
    localparam int TOUT  = 300;
    localparam int HALF  = 20;
`ifdef PS2_BREAK_EVENTS_EN
    localparam int LW = 6;
`else
    localparam int LW = 5;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          kbdclk;
    logic          kbddat;
    logic [LW-1:0] letter_out;
    logic          letter_valid;
    logic          letter_ready;
    logic [2:0]    fifo_count;
    logic [LW-1:0] last_letter;
    logic          overflow;
    logic          frame_err;
    logic          err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    // Scancodes of A..Z, Space, Enter, Backspace; the index is the letter code.
    logic [7:0] scan_tab [0:28] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A, 8'h29, 8'h5A, 8'h66};

    logic [LW-1:0] exp_q [$];
    logic          exp_ext, exp_brk, exp_ovf, exp_ferr;
    logic [LW-1:0] exp_last;

    ps2_letter_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst(rst), .kbdclk(kbdclk), .kbddat(kbddat),
        .letter_out(letter_out), .letter_valid(letter_valid), .letter_ready(letter_ready),
        .fifo_count(fifo_count), .last_letter(last_letter), .overflow(overflow),
        .frame_err(frame_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 29; i++) begin
            if (scan_tab[i] == b) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_ext  = 1'b0;
        exp_brk  = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        exp_last = LW'(5'h1F);
    endtask

    task automatic model_push(input logic [LW-1:0] v);
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
        else exp_ovf = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad);
        int idx;
        if (bad) begin
            exp_ferr = 1'b1;
            return;
        end
        if (b == 8'hE0) exp_ext = 1'b1;
        else if (b == 8'hF0) exp_brk = 1'b1;
        else begin
            idx = lookup(b);
            if (idx >= 0 && !exp_ext) begin
`ifdef PS2_BREAK_EVENTS_EN
                model_push({exp_brk, 5'(idx)});
                if (!exp_brk) exp_last = {1'b0, 5'(idx)};
`else
                if (!exp_brk) begin
                    model_push(5'(idx));
                    exp_last = 5'(idx);
                end
`endif
            end
            exp_ext = 1'b0;
            exp_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input logic d);
        kbddat = d;
        repeat (HALF) @(posedge clk);
        #1 kbdclk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 kbdclk = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        logic [10:0] f;
        f = {1'b1, ~(^b), b, 1'b0};
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    // Full frame. clr_edge/pop_edge hold err_clr / pulse letter_ready around the given edge after
    // the stop-bit fall; rise returns the first such edge at which letter_valid is seen high.
    task automatic send_frame(input logic [7:0] b, input bit bad, input int clr_edge,
                              input int pop_edge, output int rise);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ bad, b, 1'b0};
        if (clr_edge > 0) err_clr = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        kbddat = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 kbdclk = 1'b0;
        rise = 0;
        for (int e = 1; e <= HALF; e++) begin
            if (e == pop_edge) letter_ready = 1'b1;
            @(posedge clk);
            #1;
            letter_ready = 1'b0;
            if (e == clr_edge) err_clr = 1'b0;
            if (rise == 0 && letter_valid) rise = e;
        end
        kbdclk = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic pop_one(output logic [LW-1:0] v);
        v = letter_out;
        letter_ready = 1'b1;
        @(posedge clk);
        #1 letter_ready = 1'b0;
    endtask

    task automatic clr_errors();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; kbdclk = 1'b1; kbddat = 1'b1; letter_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (letter_out !== LW'(0)) begin n_bad++; $display("FAIL rst_letter_out: got %0h want 0", letter_out); end
        n_cmp++; if (letter_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", letter_valid); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        n_cmp++; if (last_letter !== LW'(5'h1F)) begin n_bad++; $display("FAIL rst_last: got %0h want 1f", last_letter); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_frame_err: got %0b want 0", frame_err); end
        rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_single_make();
        int rise;
        logic [LW-1:0] v;
        send_frame(8'h1C, 1'b0, 0, 0, rise);
        model_frame(8'h1C, 1'b0);
        // Two sync flops put the fall pulse after edge 2 (cycle E); valid is visible after edge 5 (E+3).
        n_cmp++; if (rise !== 5) begin n_bad++; $display("FAIL make_latency: got edge %0d want edge 5", rise); end
        n_cmp++; if (letter_out !== LW'(0)) begin n_bad++; $display("FAIL make_letter: got %0h want 0", letter_out); end
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL make_count: got %0d want 1", fifo_count); end
        n_cmp++; if (last_letter !== LW'(0)) begin n_bad++; $display("FAIL make_last: got %0h want 0", last_letter); end
        pop_one(v);
        n_cmp++; if (v !== exp_q[0]) begin n_bad++; $display("FAIL make_pop: got %0h want %0h", v, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++; if (letter_valid !== 1'b0 || fifo_count !== 3'd0) begin n_bad++; $display("FAIL make_empty: got valid %0b count %0d want 0/0", letter_valid, fifo_count); end
    endtask

    task automatic test_break_prefix();
        int rise;
        logic [LW-1:0] v;
        send_frame(8'hF0, 1'b0, 0, 0, rise); model_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0, 0, 0, rise); model_frame(8'h1C, 1'b0);
        send_frame(8'h1A, 1'b0, 0, 0, rise); model_frame(8'h1A, 1'b0);
`ifdef PS2_BREAK_EVENTS_EN
        n_cmp++; if (fifo_count !== 3'd2 || letter_out !== 6'h20) begin n_bad++; $display("FAIL brk_head: got count %0d head %0h want 2/20", fifo_count, letter_out); end
`else
        n_cmp++; if (fifo_count !== 3'd1 || letter_out !== 5'd25) begin n_bad++; $display("FAIL brk_head: got count %0d head %0h want 1/19", fifo_count, letter_out); end
`endif
        n_cmp++; if (last_letter !== LW'(25)) begin n_bad++; $display("FAIL brk_last: got %0h want 19", last_letter); end
        while (exp_q.size() > 0) begin
            pop_one(v);
            n_cmp++; if (v !== exp_q[0]) begin n_bad++; $display("FAIL brk_pop: got %0h want %0h", v, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL brk_drain: got %0d want 0", fifo_count); end
    endtask

    task automatic test_parity_err();
        int rise;
        // err_clr is held through the checking edge: the new error must win.
        send_frame(8'h24, 1'b1, 4, 0, rise);
        model_frame(8'h24, 1'b1);
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL par_err_set: got %0b want 1", frame_err); end
        n_cmp++; if (fifo_count !== 3'd0 || rise !== 0) begin n_bad++; $display("FAIL par_no_push: got count %0d rise %0d want 0/0", fifo_count, rise); end
        clr_errors();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL par_err_clr: got %0b want 0", frame_err); end
    endtask

    task automatic test_overflow();
        int rise;
        logic [7:0] b;
        logic [LW-1:0] v;
        for (int k = 0; k < 5; k++) begin
            b = scan_tab[$urandom_range(0, 28)];
            send_frame(b, 1'b0, 0, 0, rise);
            model_frame(b, 1'b0);
        end
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        n_cmp++; if (letter_out !== exp_q[0]) begin n_bad++; $display("FAIL ovf_head: got %0h want %0h", letter_out, exp_q[0]); end
        clr_errors();
        // Pop exactly in the push cycle while full: both happen, no overflow.
        b = scan_tab[$urandom_range(0, 28)];
        send_frame(b, 1'b0, 0, 5, rise);
        void'(exp_q.pop_front());
        model_frame(b, 1'b0);
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_pushpop_count: got %0d want 4", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pushpop_flag: got %0b want 0", overflow); end
        while (exp_q.size() > 0) begin
            pop_one(v);
            n_cmp++; if (v !== exp_q[0]) begin n_bad++; $display("FAIL ovf_pop: got %0h want %0h", v, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_timeout();
        int rise;
        logic [LW-1:0] v;
        send_partial(8'h3A, 6);
        repeat (TOUT + 10) @(posedge clk);
        #1;
        send_frame(8'h29, 1'b0, 0, 0, rise);
        model_frame(8'h29, 1'b0);
        n_cmp++; if (letter_out !== LW'(26) || fifo_count !== 3'd1) begin n_bad++; $display("FAIL timeout_letter: got %0h count %0d want 1a/1", letter_out, fifo_count); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL timeout_ferr: got %0b want 0", frame_err); end
        pop_one(v);
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_midframe();
        int rise;
        logic [LW-1:0] v;
        send_frame(8'h2B, 1'b0, 0, 0, rise); model_frame(8'h2B, 1'b0);
        send_frame(8'h24, 1'b1, 0, 0, rise); model_frame(8'h24, 1'b1);
        send_partial(8'h5A, 4);
        rst = 1'b1;
        #2;
        n_cmp++; if (letter_valid !== 1'b0 || fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_rst_fifo: got valid %0b count %0d want 0/0", letter_valid, fifo_count); end
        n_cmp++; if (letter_out !== LW'(0)) begin n_bad++; $display("FAIL mid_rst_out: got %0h want 0", letter_out); end
        n_cmp++; if (last_letter !== LW'(5'h1F)) begin n_bad++; $display("FAIL mid_rst_last: got %0h want 1f", last_letter); end
        n_cmp++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: got ferr %0b ovf %0b want 0/0", frame_err, overflow); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b0, 0, 0, rise);
        model_frame(8'h5A, 1'b0);
        n_cmp++; if (letter_out !== LW'(27) || fifo_count !== 3'd1) begin n_bad++; $display("FAIL mid_rst_enter: got %0h count %0d want 1b/1", letter_out, fifo_count); end
        n_cmp++; if (last_letter !== LW'(27)) begin n_bad++; $display("FAIL mid_rst_enter_last: got %0h want 1b", last_letter); end
        pop_one(v);
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        int rise;
        int sel;
        bit bad;
        logic [7:0] b;
        logic [LW-1:0] v;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            bad = 1'b0;
            if (sel <= 5) b = scan_tab[$urandom_range(0, 28)];
            else if (sel == 6) b = 8'hE0;
            else if (sel == 7) b = 8'hF0;
            else if (sel == 8) b = 8'($urandom_range(0, 255));
            else begin
                b = scan_tab[$urandom_range(0, 28)];
                bad = 1'b1;
            end
            send_frame(b, bad, 0, 0, rise);
            model_frame(b, bad);
            n_cmp++; if (fifo_count !== 3'(exp_q.size())) begin n_bad++; $display("FAIL rand_count: byte %0h got %0d want %0d", b, fifo_count, exp_q.size()); end
            n_cmp++; if (last_letter !== exp_last) begin n_bad++; $display("FAIL rand_last: byte %0h got %0h want %0h", b, last_letter, exp_last); end
            n_cmp++; if (overflow !== exp_ovf || frame_err !== exp_ferr) begin n_bad++; $display("FAIL rand_flags: got ovf %0b ferr %0b want %0b/%0b", overflow, frame_err, exp_ovf, exp_ferr); end
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                pop_one(v);
                n_cmp++; if (v !== exp_q[0]) begin n_bad++; $display("FAIL rand_pop: got %0h want %0h", v, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (n % 10 == 9) clr_errors();
        end
        while (exp_q.size() > 0) begin
            pop_one(v);
            n_cmp++; if (v !== exp_q[0]) begin n_bad++; $display("FAIL rand_drain: got %0h want %0h", v, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        n_cmp++; if (letter_valid !== 1'b0) begin n_bad++; $display("FAIL rand_empty: got %0b want 0", letter_valid); end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_break_prefix();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
